// File: rtl/rate_div_pkg.sv
// rate_div_pkg: shared constants, channel state encoding and reload helper for the rate divider
package rate_div_pkg;
  localparam int unsigned SYS_CLK_HZ = 50_000_000;
  typedef enum logic {RUN = 1'b0, DONE = 1'b1} ch_state_t;
  function automatic int unsigned hz_to_reload(input int unsigned hz);
    return SYS_CLK_HZ / (2 * hz) - 1;
  endfunction
endpackage

// File: rtl/rate_divider_multi_if.sv
// rate_divider_multi_if: control and strobe bundle between a timebase user and the divider
interface rate_divider_multi_if #(parameter int NUM_CH = 4, parameter int CNT_W = 32);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] mode;
  logic              sync;
  logic              div_wr;
  logic [CH_W-1:0]   div_ch;
  logic [CNT_W-1:0]  div_val;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] wave;
  logic [NUM_CH-1:0] done;
  modport master(output en, mode, sync, div_wr, div_ch, div_val, input tick, wave, done);
  modport slave(input en, mode, sync, div_wr, div_ch, div_val, output tick, wave, done);
endinterface

// File: rtl/rate_div_channel.sv
// rate_div_channel: one reloadable down-counter producing tick, square wave and one-shot done
module rate_div_channel
  import rate_div_pkg::*;
#(
  parameter int          CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 24_999_999
) (
  input  logic             clkin,
  input  logic             resetn,
  input  logic             en,
  input  logic             mode,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] val,
  output logic             tick,
  output logic             wave,
  output logic             done
);
  localparam logic [CNT_W-1:0] RST_R = CNT_W'(DEFAULT_DIV);
  logic [CNT_W-1:0] r;
  logic [CNT_W-1:0] c;
  ch_state_t        st;
  // write beats sync beats terminal count; a halted one-shot waits for write or sync
  always_ff @(posedge clkin or negedge resetn)
    if (!resetn) begin
      r    <= RST_R;
      c    <= RST_R;
      tick <= 1'b0;
      wave <= 1'b0;
      done <= 1'b0;
      st   <= RUN;
    end else if (wr) begin
      r    <= val;
      c    <= val;
      tick <= 1'b0;
      wave <= 1'b0;
      done <= 1'b0;
      st   <= RUN;
    end else if (sync) begin
      c    <= r;
      tick <= 1'b0;
      wave <= 1'b0;
      done <= 1'b0;
      st   <= RUN;
    end else if (st == RUN && en && c == '0) begin
      tick <= 1'b1;
      wave <= ~wave;
      c    <= r;
      if (mode) begin
        st   <= DONE;
        done <= 1'b1;
      end
    end else begin
      tick <= 1'b0;
      if (st == RUN && en) c <= c - CNT_W'(1);
    end
endmodule

// File: rtl/rate_divider_multi.sv
// rate_divider_multi: bank of independent programmable tick/square-wave channels
module rate_divider_multi
  import rate_div_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 24_999_999
) (
  input logic                 clkin,
  input logic                 resetn,
  rate_divider_multi_if.slave bus
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rate_div_channel #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .clkin  (clkin),
      .resetn (resetn),
      .en     (bus.en[i]),
      .mode   (bus.mode[i]),
      .sync   (bus.sync),
      .wr     (bus.div_wr && bus.div_ch == CH_W'(i)),
      .val    (bus.div_val),
      .tick   (bus.tick[i]),
      .wave   (bus.wave[i]),
      .done   (bus.done[i])
    );
  end
endmodule

// File: tb/tb_rate_divider_multi.sv
// tb_rate_divider_multi: directed and random checks against an elapsed-cycle reference model
module tb_rate_divider_multi;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int n = 0;
  int errs = 0;
  longint unsigned e[4];
  longint unsigned rl[4];
  int nt[4];
  logic [3:0] xt, xw, xd;
  int cnt;

  rate_divider_multi_if #(.NUM_CH(4), .CNT_W(32)) m();
  rate_divider_multi_if #(.NUM_CH(3), .CNT_W(8)) b();

  rate_divider_multi #(.NUM_CH(4), .CNT_W(32), .DEFAULT_DIV(9)) dut (
    .clkin(clk), .resetn(resetn), .bus(m.slave));
  rate_divider_multi #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(5)) dut8 (
    .clkin(clk), .resetn(resetn), .bus(b.slave));

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // model: a channel ticks whenever its enabled cycles since (re)start reach a multiple of R+1
  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      if (!resetn) begin
        rl[i] = 9; e[i] = 0; nt[i] = 0; xd[i] = 0; xt[i] = 0;
      end else if (m.div_wr && m.div_ch == i) begin
        rl[i] = m.div_val; e[i] = 0; nt[i] = 0; xd[i] = 0; xt[i] = 0;
      end else if (m.sync) begin
        e[i] = 0; nt[i] = 0; xd[i] = 0; xt[i] = 0;
      end else if (!xd[i] && m.en[i]) begin
        e[i]++;
        xt[i] = (e[i] % (rl[i] + 1)) == 0;
        if (xt[i]) begin
          nt[i]++;
          if (m.mode[i]) xd[i] = 1'b1;
        end
      end else xt[i] = 1'b0;
      xw[i] = nt[i][0];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("tick", m.tick, xt);
    chk("wave", m.wave, xw);
    chk("done", m.done, xd);
  endtask

  initial begin
    m.en = '0; m.mode = '0; m.sync = 0; m.div_wr = 0; m.div_ch = '0; m.div_val = '0;
    b.en = '0; b.mode = '0; b.sync = 0; b.div_wr = 0; b.div_ch = '0; b.div_val = '0;
    step(); step();
    resetn = 1'b1; m.en = 4'hf;
    repeat (5) step();
    resetn = 1'b0;
    #1;
    chk("rst_async", {m.tick, m.wave, m.done}, 0);
    step();
    resetn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("rst_first_tick", m.tick, k == 10 ? 4'hf : 4'h0);
    end
    // periodic R=3 on ch0
    m.div_wr = 1; m.div_ch = 0; m.div_val = 3;
    step();
    m.div_wr = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("per_tick", m.tick[0], k % 4 == 0);
      if (k % 4 == 0) chk("per_wave", m.wave[0], (k / 4) & 1);
    end
    // one-shot R=5 on ch1
    m.mode[1] = 1; m.div_wr = 1; m.div_ch = 1; m.div_val = 5;
    step();
    m.div_wr = 0;
    for (int k = 1; k <= 56; k++) begin
      step();
      chk("os_tick", m.tick[1], k == 6);
      if (k >= 6) chk("os_done", m.done[1], 1);
    end
    m.div_wr = 1; m.div_ch = 1; m.div_val = 5;
    step();
    m.div_wr = 0;
    chk("os_rewrite_done", m.done[1], 0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("os_retick", m.tick[1], k == 6);
    end
    // enable gap on ch2 R=7 at C=4
    m.div_wr = 1; m.div_ch = 2; m.div_val = 7;
    step();
    m.div_wr = 0;
    repeat (3) step();
    m.en[2] = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("gap_tick", m.tick[2], 0);
      chk("gap_wave", m.wave[2], 0);
    end
    m.en[2] = 1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("gap_resume", m.tick[2], k == 5);
    end
    // write ch0 R=2 exactly when C==0
    for (int g = 0; g < 10 && ((e[0] + 1) % (rl[0] + 1)) != 0; g++) step();
    chk("coll_align", 32'((e[0] + 1) % (rl[0] + 1)), 0);
    m.div_wr = 1; m.div_ch = 0; m.div_val = 2;
    step();
    m.div_wr = 0;
    chk("coll_tick", m.tick[0], 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("coll_next", m.tick[0], k == 3);
    end
    // sync with simultaneous write to ch3
    m.sync = 1; m.div_wr = 1; m.div_ch = 3; m.div_val = 4;
    step();
    m.sync = 0; m.div_wr = 0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("sync_ch3", m.tick[3], k == 5);
      chk("sync_ch0", m.tick[0], k == 3);
    end
    // R=0 on ch2
    m.div_wr = 1; m.div_ch = 2; m.div_val = 0;
    step();
    m.div_wr = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("r0_tick", m.tick[2], 1);
      chk("r0_wave", m.wave[2], k & 1);
    end
    // randomized traffic
    repeat (300) begin
      m.en = 4'($urandom);
      m.mode = 4'($urandom);
      m.sync = $urandom_range(0, 19) == 0;
      m.div_wr = $urandom_range(0, 9) == 0;
      m.div_ch = 2'($urandom);
      m.div_val = 32'($urandom_range(0, 7));
      step();
    end
    m.sync = 0; m.div_wr = 0; m.en = '0;
    // 8-bit, 3-channel instance: out-of-range write ignored
    b.en = 3'b111; b.div_wr = 1; b.div_ch = 3; b.div_val = 1;
    for (int k = 1; k <= 6; k++) begin
      step();
      b.div_wr = 0;
      chk("bad_ch_tick", b.tick, k == 6 ? 3'b111 : 3'b000);
    end
    // full-range reload R=255 on an 8-bit counter
    b.div_wr = 1; b.div_ch = 0; b.div_val = 8'hff;
    step();
    b.div_wr = 0;
    for (int p = 0; p < 2; p++) begin
      cnt = 0;
      do begin
        step();
        cnt++;
      end while (!b.tick[0] && cnt < 300);
      chk("r255_period", cnt, 256);
      chk("r255_wave", b.wave[0], p == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
